// File: rtl/pipelined_accum_tree_adder.sv
// pipelined_accum_tree_adder
//   Pipelined binary-tree reduction of INPUTS_AMOUNT signed operands per beat,
//   followed by a multi-beat accumulator that sums beat results over a group
//   terminated by in_last. Each beat is either full precision (one P-bit
//   operand per input) or halved precision (two signed P/2-bit lanes per input).
//
//   Optional feature macro: TREE_ADDER_SATURATE_EN
//     defined   -> accumulator adds clamp to the signed OUT_WIDTH range and
//                  out_overflow reports any clamp within the group (sticky)
//     undefined -> accumulator adds wrap, out_overflow is tied to 0
//
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   inputs[N]        : signed operands of the beat (P bits each)
//   halvedPrecision  : beat mode, sampled with the beat
//   in_valid/in_last : beat present / beat closes its group
//   in_ready         : beat can be accepted this cycle (= pipeline advance)
//   out              : signed group sum (OUT_WIDTH bits)
//   out_count        : beats in the group, saturating at all-ones
//   out_overflow     : group result was clipped (saturating build only)
//   out_valid        : group result present
//   out_ready        : downstream accepts the result
module pipelined_accum_tree_adder #(
  parameter int INPUTS_AMOUNT = 8,
  parameter int P             = 8,
  parameter int STAGE_LAYERS  = 1,
  parameter int OUT_WIDTH     = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [P-1:0]         inputs [INPUTS_AMOUNT],
  input  logic                 halvedPrecision,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_overflow,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int L  = $clog2(INPUTS_AMOUNT);
  localparam int BW = P + L;                                   // exact beat-sum width
  localparam int HP = P / 2;
  localparam int S  = (L + STAGE_LAYERS - 1) / STAGE_LAYERS;   // tree register stages

  // Elaboration-time parameter legality checks
  if (INPUTS_AMOUNT < 2 || (INPUTS_AMOUNT & (INPUTS_AMOUNT - 1)) != 0) begin : g_bad_inputs
    $fatal(1, "INPUTS_AMOUNT must be a power of 2 and >= 2");
  end
  if ((P % 2) != 0 || P < 2) begin : g_bad_p
    $fatal(1, "P must be even");
  end
  if (STAGE_LAYERS < 1) begin : g_bad_layers
    $fatal(1, "STAGE_LAYERS must be >= 1");
  end
  if (OUT_WIDTH < P + L + 1) begin : g_bad_out_width
    $fatal(1, "OUT_WIDTH must be >= P + clog2(INPUTS_AMOUNT) + 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // A tree level is registered every STAGE_LAYERS layers and always at the root.
  function automatic logic is_reg_level(input int k);
    return (k >= 1) && ((k == L) || ((k % STAGE_LAYERS) == 0));
  endfunction

  // Saturation build: returns {clamped, sum}
`ifdef TREE_ADDER_SATURATE_EN
  function automatic logic [OUT_WIDTH:0] acc_add(input logic signed [OUT_WIDTH-1:0] a,
                                                 input logic signed [OUT_WIDTH-1:0] b);
    logic signed [OUT_WIDTH:0] wide;
    wide = (OUT_WIDTH+1)'(a) + (OUT_WIDTH+1)'(b);
    if (wide[OUT_WIDTH] != wide[OUT_WIDTH-1]) begin
      if (wide[OUT_WIDTH]) begin
        return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
        return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end else begin
      return {1'b0, wide[OUT_WIDTH-1:0]};
    end
  endfunction
`else
  function automatic logic [OUT_WIDTH-1:0] acc_add(input logic signed [OUT_WIDTH-1:0] a,
                                                   input logic signed [OUT_WIDTH-1:0] b);
    return a + b;
  endfunction
`endif

  logic                        en;
  logic signed [BW-1:0]        lvl_sum [L+1][INPUTS_AMOUNT];
  logic signed [BW-1:0]        lvl_q   [L+1][INPUTS_AMOUNT];
  logic                        v_q     [1:S];
  logic                        last_q  [1:S];
  logic signed [OUT_WIDTH-1:0] beat_ext;
  logic signed [OUT_WIDTH-1:0] acc_q;
  logic signed [OUT_WIDTH-1:0] add_sum;
  logic [CNT_WIDTH-1:0]        cnt_q;
  logic [CNT_WIDTH-1:0]        cnt_inc;
  state_t                      state;
`ifdef TREE_ADDER_SATURATE_EN
  logic                        add_ovf;
  logic                        ovf_q;
  logic                        out_ovf_q;
`endif

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign beat_ext = OUT_WIDTH'(lvl_q[L][0]);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // Leaf formation (mode-dependent sign extension) and the adder layers.
  // A layer reads the register of the previous level when that level is
  // registered, otherwise its combinational sums.
  always_comb begin
    for (int k = 0; k <= L; k++) begin
      for (int i = 0; i < INPUTS_AMOUNT; i++) begin
        lvl_sum[k][i] = '0;
      end
    end
    for (int i = 0; i < INPUTS_AMOUNT; i++) begin
      if (halvedPrecision) begin
        lvl_sum[0][i] = BW'($signed(inputs[i][P-1:HP])) + BW'($signed(inputs[i][HP-1:0]));
      end else begin
        lvl_sum[0][i] = BW'($signed(inputs[i]));
      end
    end
    for (int k = 1; k <= L; k++) begin
      for (int i = 0; i < (INPUTS_AMOUNT >> k); i++) begin
        if (is_reg_level(k - 1)) begin
          lvl_sum[k][i] = lvl_q[k-1][2*i] + lvl_q[k-1][2*i+1];
        end else begin
          lvl_sum[k][i] = lvl_sum[k-1][2*i] + lvl_sum[k-1][2*i+1];
        end
      end
    end
  end

  // Accumulator add result for the beat leaving the tree
  always_comb begin
`ifdef TREE_ADDER_SATURATE_EN
    {add_ovf, add_sum} = acc_add(acc_q, beat_ext);
`else
    add_sum = acc_add(acc_q, beat_ext);
`endif
  end

  // Tree pipeline registers with valid/last tags; the whole pipe advances on en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= L; k++) begin
        for (int i = 0; i < INPUTS_AMOUNT; i++) begin
          lvl_q[k][i] <= '0;
        end
      end
      for (int s = 1; s <= S; s++) begin
        v_q[s]    <= 1'b0;
        last_q[s] <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k <= L; k++) begin
        for (int i = 0; i < INPUTS_AMOUNT; i++) begin
          if (is_reg_level(k)) begin
            lvl_q[k][i] <= lvl_sum[k][i];
          end else begin
            lvl_q[k][i] <= '0;
          end
        end
      end
      v_q[1]    <= in_valid;
      last_q[1] <= in_last;
      for (int s = 2; s <= S; s++) begin
        v_q[s]    <= v_q[s-1];
        last_q[s] <= last_q[s-1];
      end
    end
  end

  // Group accumulator FSM and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      out       <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
`ifdef TREE_ADDER_SATURATE_EN
      ovf_q     <= 1'b0;
      out_ovf_q <= 1'b0;
`endif
    end else if (en) begin
      // en implies any held result is being consumed now
      out_valid <= 1'b0;
      if (v_q[S]) begin
        case (state)
          IDLE: begin
            if (last_q[S]) begin
              out       <= beat_ext;
              out_count <= CNT_WIDTH'(1);
              out_valid <= 1'b1;
`ifdef TREE_ADDER_SATURATE_EN
              out_ovf_q <= 1'b0;
`endif
            end else begin
              acc_q <= beat_ext;
              cnt_q <= CNT_WIDTH'(1);
              state <= ACCUM;
`ifdef TREE_ADDER_SATURATE_EN
              ovf_q <= 1'b0;
`endif
            end
          end
          ACCUM: begin
            if (last_q[S]) begin
              out       <= add_sum;
              out_count <= cnt_inc;
              out_valid <= 1'b1;
              acc_q     <= '0;
              cnt_q     <= '0;
              state     <= IDLE;
`ifdef TREE_ADDER_SATURATE_EN
              out_ovf_q <= ovf_q | add_ovf;
              ovf_q     <= 1'b0;
`endif
            end else begin
              acc_q <= add_sum;
              cnt_q <= cnt_inc;
`ifdef TREE_ADDER_SATURATE_EN
              ovf_q <= ovf_q | add_ovf;
`endif
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef TREE_ADDER_SATURATE_EN
  assign out_overflow = out_ovf_q;
`else
  assign out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_accum_tree_adder.sv
// Self-checking bench for pipelined_accum_tree_adder: a vector table of beats
// with expected group results, a scoreboard popped by an output monitor, and
// hand-written sequences for latency, backpressure, reset and overflow.
module tb_pipelined_accum_tree_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ops [8];
  logic        halved;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out;
  logic [15:0] out_count;
  logic        out_overflow;
  logic        out_valid;
  logic        out_ready;

  // Second instance with a narrow accumulator for the overflow case
  logic [7:0]  s_ops [8];
  logic        s_valid;
  logic        s_last;
  logic        s_in_ready;
  logic [11:0] s_out;
  logic [15:0] s_count;
  logic        s_ovf;
  logic        s_out_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] out;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;
  exp_t sb [$];

  typedef struct {
    logic [7:0] op;
    logic       hv;
    logic       last;
    int         exp_out;
    int         exp_cnt;
  } vec_t;
  vec_t vecs [9];

  pipelined_accum_tree_adder dut (
    .clk(clk), .rst(rst), .inputs(ops), .halvedPrecision(halved),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out(out), .out_count(out_count), .out_overflow(out_overflow),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  pipelined_accum_tree_adder #(.OUT_WIDTH(12)) dut12 (
    .clk(clk), .rst(rst), .inputs(s_ops), .halvedPrecision(1'b0),
    .in_valid(s_valid), .in_last(s_last), .in_ready(s_in_ready),
    .out(s_out), .out_count(s_count), .out_overflow(s_ovf),
    .out_valid(s_out_valid), .out_ready(1'b1)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input logic ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input logic [7:0] v);
    for (int i = 0; i < 8; i++) ops[i] = v;
  endtask

  // Present one beat, wait until accepted, push the group result if last
  task automatic beat(input logic [7:0] op, input logic hv, input logic last,
                      input int exp_out, input int exp_cnt);
    int n;
    set_ops(op);
    halved   = hv;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk(1'b0, "accept_timeout", 0, 1);
    if (last) sb.push_back('{out: 32'(exp_out), cnt: 16'(exp_cnt), ovf: 1'b0});
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(sb.size() == 0, "drain_empty", sb.size(), 0);
  endtask

  // Output monitor: compares every consumed result against the scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_result", $signed(out), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (out !== e.out || out_count !== e.cnt || out_overflow !== e.ovf) begin
          errors++;
          $display("FAIL result: got out=%0d cnt=%0d ovf=%0b expected out=%0d cnt=%0d ovf=%0b",
                   $signed(out), out_count, out_overflow, $signed(e.out), e.cnt, e.ovf);
        end
      end
    end
  end

  initial begin
    int n;
    vecs[0] = '{op: 8'h7F, hv: 1'b0, last: 1'b1, exp_out: 1016, exp_cnt: 1};
    vecs[1] = '{op: 8'h12, hv: 1'b1, last: 1'b1, exp_out: 24,   exp_cnt: 1};
    vecs[2] = '{op: 8'hF1, hv: 1'b1, last: 1'b1, exp_out: 0,    exp_cnt: 1};
    vecs[3] = '{op: 8'h01, hv: 1'b0, last: 1'b0, exp_out: 0,    exp_cnt: 0};
    vecs[4] = '{op: 8'h11, hv: 1'b1, last: 1'b0, exp_out: 0,    exp_cnt: 0};
    vecs[5] = '{op: 8'hFF, hv: 1'b0, last: 1'b1, exp_out: 16,   exp_cnt: 3};
    vecs[6] = '{op: 8'h80, hv: 1'b0, last: 1'b1, exp_out: -1024, exp_cnt: 1};
    vecs[7] = '{op: 8'h80, hv: 1'b1, last: 1'b1, exp_out: -64,  exp_cnt: 1};
    vecs[8] = '{op: 8'h7F, hv: 1'b1, last: 1'b1, exp_out: 48,   exp_cnt: 1};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; halved = 1'b0; out_ready = 1'b1;
    set_ops(8'h00);
    s_valid = 1'b0; s_last = 1'b0;
    for (int i = 0; i < 8; i++) s_ops[i] = 8'h80;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    chk(out == 32'd0, "rst_out", out, 0);
    chk(out_count == 16'd0, "rst_out_count", out_count, 0);
    chk(out_overflow == 1'b0, "rst_overflow", out_overflow, 0);
    chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);

    // Latency: beat presented in cycle 0, result valid in cycle 4
    set_ops(8'h7F); halved = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    sb.push_back('{out: 32'd1016, cnt: 16'd1, ovf: 1'b0});
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk(n == 4, "latency", n, 4);
    drain();

    // Table-driven beats, issued back to back
    for (int v = 0; v < 9; v++) begin
      beat(vecs[v].op, vecs[v].hv, vecs[v].last, vecs[v].exp_out, vecs[v].exp_cnt);
    end
    drain();

    // Backpressure: fill the pipe with single-beat groups while out_ready is low
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) beat(8'(k), 1'b0, 1'b1, 8 * k, 1);
    set_ops(8'h05); halved = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk(in_ready == 1'b0, "stall_in_ready", in_ready, 0);
      chk(out == 32'd8 && out_valid == 1'b1, "stall_out_stable", $signed(out), 8);
      tick();
    end
    out_ready = 1'b1;
    sb.push_back('{out: 32'd40, cnt: 16'd1, ovf: 1'b0});
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (4) tick();
    chk(sb.size() == 0, "release_one_per_cycle", sb.size(), 0);
    chk(out_valid == 1'b0, "release_no_duplicate", out_valid, 0);
    drain();

    // Reset in the middle of a 4-beat group discards it
    beat(8'h01, 1'b0, 1'b0, 0, 0);
    beat(8'h01, 1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(out_valid == 1'b0, "midreset_out_valid", out_valid, 0);
    chk(in_ready == 1'b1, "midreset_in_ready", in_ready, 1);
    beat(8'h01, 1'b0, 1'b1, 8, 1);
    drain();

    // Overflow on the 12-bit accumulator: three beats of -1024
    for (int b = 0; b < 3; b++) begin
      s_valid = 1'b1;
      s_last  = (b == 2);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    n = 0;
    while (!s_out_valid && n < 20) begin
      tick();
      n++;
    end
    chk(s_out_valid == 1'b1, "ovf_result_valid", s_out_valid, 1);
    chk(s_count == 16'd3, "ovf_count", s_count, 3);
`ifdef TREE_ADDER_SATURATE_EN
    chk(s_out == 12'h800, "ovf_out_sat", $signed(s_out), -2048);
    chk(s_ovf == 1'b1, "ovf_flag_sat", s_ovf, 1);
`else
    chk(s_out == 12'h400, "ovf_out_wrap", $signed(s_out), 1024);
    chk(s_ovf == 1'b0, "ovf_flag_wrap", s_ovf, 0);
`endif

    repeat (5) tick();
    chk(sb.size() == 0, "final_scoreboard", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
